// File: rtl/s_cla_sacc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sacc_pkg
// Shared types and constants for the bit-serial shift-accumulate sequencer.
//   state_t  : sequencer states (IDLE, ACC, OUT)
//   ACC_W    : accumulator / adder width (fixed at 24)
//   SAT_MAX  : most positive 24-bit signed value (saturation target)
//   SAT_MIN  : most negative 24-bit signed value (saturation target)
//   sext()   : sign-extend the low w bits of a vector to ACC_W bits
// -----------------------------------------------------------------------------
package sacc_pkg;

    localparam int ACC_W = 24;

    localparam logic [ACC_W-1:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [ACC_W-1:0] SAT_MIN = 24'h800000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Replicates bit w-1 of v into every bit at or above w.
    function automatic logic [ACC_W-1:0] sext(input logic [ACC_W-1:0] v, input int w);
        logic [ACC_W-1:0] r;
        r = v;
        for (int i = 0; i < ACC_W; i++) begin
            if (i >= w) begin
                r[i] = v[w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/s_cla_sacc_ctrl_if.sv
// -----------------------------------------------------------------------------
// s_cla_sacc_ctrl_if
// Control, partial-sum stream and result stream of the shift-accumulate
// sequencer.
//   start, in_signed        : accumulation request and activation signedness
//   psum, psum_valid/ready  : partial-sum input stream, one beat per bit, MSB first
//   res, res_valid/ready    : accumulated result stream, one result per start
//   ovf                     : sticky overflow, qualified by res_valid
//   busy                    : sequencer is accumulating or presenting a result
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer keeps data stable while
// valid is high and ready is low; ready never depends on valid.
//
// Modports: master = producer of psum / consumer of res (upstream+downstream
// side), slave = the sequencer.
// -----------------------------------------------------------------------------
interface s_cla_sacc_ctrl_if
    import sacc_pkg::*;
#(
    parameter int PSUM_W = 16
);

    logic              start;
    logic              in_signed;
    logic [PSUM_W-1:0] psum;
    logic              psum_valid;
    logic              psum_ready;
    logic [ACC_W-1:0]  res;
    logic              res_valid;
    logic              res_ready;
    logic              ovf;
    logic              busy;

    modport master (
        output start, in_signed, psum, psum_valid, res_ready,
        input  psum_ready, res, res_valid, ovf, busy
    );

    modport slave (
        input  start, in_signed, psum, psum_valid, res_ready,
        output psum_ready, res, res_valid, ovf, busy
    );

endinterface

// File: rtl/s_cla_sacc_ctrl_cla.sv
// -----------------------------------------------------------------------------
// s_cla
// W-bit carry-lookahead adder built from 4-bit groups: the carry into each
// group comes from the previous group's generate/propagate terms, carries
// inside a group are formed from that group carry-in.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^W (W must be a multiple of 4)
// -----------------------------------------------------------------------------
module s_cla #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] c;

    always_comb begin
        logic gg;
        logic gp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < W / 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
            gg = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp = &p[4*k +: 4];
            // The carry out of the top group is not needed.
            if (k < W / 4 - 1) begin
                c[4*k+4] = gg | (gp & c[4*k]);
            end
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/s_cla_sacc_ctrl.sv
// -----------------------------------------------------------------------------
// s_cla_sacc_ctrl
// Bit-serial shift-accumulate sequencer for the DCIM readout path. Each
// accepted partial sum (one per activation bit, MSB first) is folded into a
// 24-bit accumulator as acc = 2*acc + psum; when the activation is signed the
// MSB beat is subtracted instead. One shared s_cla does the add/subtract.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : s_cla_sacc_ctrl_if.slave (start/in_signed, psum stream,
//                res stream with ovf, busy)
//   dbg_state  : current sequencer state
//
// Parameters: IN_BITS (2..16) beats per result, PSUM_W (< 24) psum width.
//
// Build option: define SACC_SAT_EN to saturate the accumulator on the first
// overflow and freeze it for the remaining beats; otherwise it wraps modulo
// 2^24 and ovf only reports.
// -----------------------------------------------------------------------------
module s_cla_sacc_ctrl
    import sacc_pkg::*;
#(
    parameter int IN_BITS = 8,
    parameter int PSUM_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    s_cla_sacc_ctrl_if.slave    bus,
    output state_t              dbg_state
);

    localparam int CNT_W = $clog2(IN_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_BITS - 1);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc,   acc_nxt;
    logic [CNT_W-1:0] cnt,   cnt_nxt;
    logic             sgn,   sgn_nxt;
    logic             ovf,   ovf_nxt;

    logic             beat;
    logic             sub;
    logic [ACC_W-1:0] op_a;
    logic [ACC_W-1:0] op_b;
    logic [ACC_W-1:0] psum_ext;
    logic [ACC_W-1:0] sum;
    logic             shift_ovf;
    logic             add_ovf;

    // ---------------- datapath operands ----------------
    always_comb begin
        beat     = (state == ACC) && bus.psum_valid;
        // The MSB of a signed activation carries negative weight.
        sub      = sgn && (cnt == '0);
        psum_ext = sext(ACC_W'(bus.psum), PSUM_W);
        op_a     = {acc[ACC_W-2:0], 1'b0};
        op_b     = sub ? ~psum_ext : psum_ext;
    end

    s_cla #(.W(ACC_W)) u_cla (
        .a   (op_a),
        .b   (op_b),
        .cin (sub),
        .sum (sum)
    );

    // Doubling overflows when the top two bits differ; the add overflows when
    // both operands share a sign the sum does not.
    assign shift_ovf = acc[ACC_W-1] ^ acc[ACC_W-2];
    assign add_ovf   = (op_a[ACC_W-1] == op_b[ACC_W-1]) && (sum[ACC_W-1] != op_a[ACC_W-1]);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sgn   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sgn   <= sgn_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sgn_nxt   = sgn;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = ACC;
                    sgn_nxt   = bus.in_signed;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            ACC: begin
                if (beat) begin
                    cnt_nxt = cnt + 1'b1;
                    ovf_nxt = ovf | shift_ovf | add_ovf;
`ifdef SACC_SAT_EN
                    if (ovf) begin
                        acc_nxt = acc;
                    end else if (shift_ovf) begin
                        acc_nxt = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
                    end else if (add_ovf) begin
                        acc_nxt = op_a[ACC_W-1] ? SAT_MIN : SAT_MAX;
                    end else begin
                        acc_nxt = sum;
                    end
`else
                    acc_nxt = sum;
`endif
                    if (cnt == LAST) begin
                        state_nxt = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign bus.psum_ready = (state == ACC);
    assign bus.res_valid  = (state == OUT);
    assign bus.res        = acc;
    assign bus.ovf        = ovf;
    assign bus.busy       = (state == ACC) || (state == OUT);
    assign dbg_state      = state;

endmodule

// File: tb/tb_s_cla_sacc_ctrl.sv
module tb_s_cla_sacc_ctrl;
    import sacc_pkg::*;

    localparam int PW = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs: IN_BITS=8 and IN_BITS=10 ----------------
    s_cla_sacc_ctrl_if #(.PSUM_W(PW)) if8 ();
    s_cla_sacc_ctrl_if #(.PSUM_W(PW)) if10 ();
    state_t st8, st10;

    s_cla_sacc_ctrl #(.IN_BITS(8), .PSUM_W(PW)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if8),
        .dbg_state (st8)
    );

    s_cla_sacc_ctrl #(.IN_BITS(10), .PSUM_W(PW)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if10),
        .dbg_state (st10)
    );

    logic [PW-1:0] psum_d       = '0;
    logic          psum_valid_d = 1'b0;
    logic          res_ready_d  = 1'b0;
    logic          in_signed_d  = 1'b0;
    logic          start8       = 1'b0;
    logic          start10      = 1'b0;

    assign if8.psum        = psum_d;
    assign if8.psum_valid  = psum_valid_d;
    assign if8.res_ready   = res_ready_d;
    assign if8.in_signed   = in_signed_d;
    assign if8.start       = start8;
    assign if10.psum       = psum_d;
    assign if10.psum_valid = psum_valid_d;
    assign if10.res_ready  = res_ready_d;
    assign if10.in_signed  = in_signed_d;
    assign if10.start      = start10;

    // Observed outputs of the DUT selected by sel (0 = IN_BITS 8, 1 = IN_BITS 10).
    int          sel = 0;
    logic        o_psum_ready, o_res_valid, o_ovf, o_busy;
    logic [23:0] o_res;
    state_t      o_st;

    always_comb begin
        if (sel == 1) begin
            o_psum_ready = if10.psum_ready;
            o_res_valid  = if10.res_valid;
            o_ovf        = if10.ovf;
            o_busy       = if10.busy;
            o_res        = if10.res;
            o_st         = st10;
        end else begin
            o_psum_ready = if8.psum_ready;
            o_res_valid  = if8.res_valid;
            o_ovf        = if8.ovf;
            o_busy       = if8.busy;
            o_res        = if8.res;
            o_st         = st8;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [24:0] exp_q[$];
    logic signed [PW-1:0] beats [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the result is the weighted sum of the beats (beat i has
    // weight 2^(nb-1-i), negated for a signed activation MSB), taken mod 2^24.
    // Overflow is the first point where the exact running value, or its
    // doubling, leaves the 24-bit signed range.
    function automatic void model(input logic sgn, input int nb,
                                  output logic [23:0] r, output logic o);
        longint total;
        longint e;
        longint two;
        longint term;
        logic   neg;
        total = 0;
        e     = 0;
        neg   = 1'b0;
        o     = 1'b0;
        for (int i = 0; i < nb; i++) begin
            term = longint'(beats[i]) * (longint'(1) << (nb - 1 - i));
            if (sgn && i == 0) term = -term;
            total += term;
        end
        for (int i = 0; i < nb; i++) begin
            if (!o) begin
                two = 2 * e;
                if (two > 8388607 || two < -8388608) begin
                    o   = 1'b1;
                    neg = (e < 0);
                end else begin
                    e = (sgn && i == 0) ? two - longint'(beats[i]) : two + longint'(beats[i]);
                    if (e > 8388607 || e < -8388608) begin
                        o   = 1'b1;
                        neg = (e < 0);
                    end
                end
            end
        end
`ifdef SACC_SAT_EN
        r = o ? (neg ? 24'h800000 : 24'h7FFFFF) : total[23:0];
`else
        r = total[23:0];
`endif
    endfunction

    // ---------------- driver ----------------
    // One full accumulation on the selected DUT: start, nb beats with the
    // chosen bubble pattern (0 none, 1 alternate, 2 random), hold cycles of
    // result backpressure with start pulses, then the result handshake.
    // Expected {ovf,res} is popped from exp_q.
    task automatic run_acc(input int which, input logic sgn, input int nb,
                           input int bub, input int hold);
        int          idx;
        int          budget;
        logic        rdy;
        logic        v;
        logic        early;
        logic [24:0] exp;
        idx    = 0;
        budget = 0;
        early  = 1'b0;
        exp    = exp_q.pop_front();
        sel          = which;
        in_signed_d  = sgn;
        res_ready_d  = 1'b0;
        psum_valid_d = 1'b0;
        if (which == 1) start10 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        start10 = 1'b0;
        check("busy_after_start", o_busy, 1);
        check("psum_ready_in_acc", o_psum_ready, 1);
        while (idx < nb && budget < 400) begin
            rdy = o_psum_ready;
            case (bub)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            psum_d       = beats[idx];
            psum_valid_d = v;
            @(negedge clk);
            budget++;
            if (v && rdy) idx++;
            if (idx < nb && o_res_valid) early = 1'b1;
        end
        psum_valid_d = 1'b0;
        check("beats_accepted", idx, nb);
        check("no_early_result", early, 0);
        check("res_valid_latency", o_res_valid, 1);
        check("res_value", o_res, exp[23:0]);
        check("ovf_value", o_ovf, exp[24]);
        for (int h = 0; h < hold; h++) begin
            if (which == 1) start10 = 1'b1; else start8 = 1'b1;
            @(negedge clk);
            check("hold_res", o_res, exp[23:0]);
            check("hold_ovf", o_ovf, exp[24]);
            check("hold_res_valid", o_res_valid, 1);
            check("hold_psum_ready", o_psum_ready, 0);
        end
        start8      = 1'b0;
        start10     = 1'b0;
        res_ready_d = 1'b1;
        @(negedge clk);
        res_ready_d = 1'b0;
        check("idle_res_valid", o_res_valid, 0);
        check("idle_busy", o_busy, 0);
        check("idle_state", o_st, IDLE);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psum_ready"}, o_psum_ready, 0);
        check({tag, "_res_valid"}, o_res_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_res"}, o_res, 0);
        check({tag, "_ovf"}, o_ovf, 0);
        check({tag, "_state"}, o_st, IDLE);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic        sgn;
        int          bub;
        int          hold;
        int          fill;    // 0: val on every beat, 1: val on beat 0 only
        logic [15:0] val;
        logic [23:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[7];

    task automatic load_beats(input int fill, input logic [15:0] val);
        for (int i = 0; i < 16; i++) begin
            beats[i] = (fill == 0 || i == 0) ? val : 16'h0000;
        end
    endtask

    initial begin
        logic [23:0] r;
        logic        o;
        int          which;
        int          nb;

        tbl[0] = '{"unsigned_ones",    1'b0, 0, 0, 0, 16'h0001, 24'h0000FF, 1'b0};
        tbl[1] = '{"signed_ones",      1'b1, 0, 0, 0, 16'h0001, 24'hFFFFFF, 1'b0};
        tbl[2] = '{"signed_msb_only",  1'b1, 0, 5, 1, 16'h0003, 24'hFFFE80, 1'b0};
        tbl[3] = '{"bubbles_neg2",     1'b0, 1, 0, 0, 16'hFFFE, 24'hFFFE02, 1'b0};
        tbl[4] = '{"signed_min_psum",  1'b1, 0, 0, 0, 16'h8000, 24'h008000, 1'b0};
        tbl[5] = '{"unsigned_max_fit", 1'b0, 0, 2, 0, 16'h7FFF, 24'h7F7F01, 1'b0};
        tbl[6] = '{"unsigned_min_fit", 1'b0, 1, 0, 0, 16'h8000, 24'h808000, 1'b0};

        // Reset state, async reset held low.
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors on IN_BITS=8.
        for (int t = 0; t < 7; t++) begin
            load_beats(tbl[t].fill, tbl[t].val);
            exp_q.push_back({tbl[t].exp_ovf, tbl[t].exp_res});
            run_acc(0, tbl[t].sgn, 8, tbl[t].bub, tbl[t].hold);
        end

        // IN_BITS=10 overflow with back-pressure.
        load_beats(0, 16'h7FFF);
`ifdef SACC_SAT_EN
        exp_q.push_back({1'b1, 24'h7FFFFF});
`else
        exp_q.push_back({1'b1, 24'hFF7C01});
`endif
        run_acc(1, 1'b0, 10, 0, 3);

        // Reset in the middle of an accumulation (after beat 4).
        sel = 0;
        for (int i = 0; i < 16; i++) beats[i] = 16'(i + 5);
        in_signed_d = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        psum_valid_d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            psum_d = beats[i];
            @(negedge clk);
        end
        check("mid_res_nonzero", (o_res != 0), 1);
        #1;
        rst_n = 1'b0;
        psum_valid_d = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beats[0] = 16'h0002;
        beats[1] = 16'hFFFF;
        for (int i = 2; i < 8; i++) beats[i] = 16'h0001;
        // -256 + 1*64... : signed: -2*128 - 64 + (32+16+8+4+2+1) = -257
        exp_q.push_back({1'b0, 24'hFFFEFF});
        run_acc(0, 1'b1, 8, 0, 0);

        // Randomized accumulations against the reference model.
        for (int n = 0; n < 24; n++) begin
            logic sgn;
            int   mode;
            which = (n % 4 == 3) ? 1 : 0;
            nb    = (which == 1) ? 10 : 8;
            sgn   = 1'($urandom_range(0, 1));
            mode  = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) begin
                case (mode)
                    0:       beats[i] = 16'($urandom_range(0, 65535));
                    1:       beats[i] = 16'($signed($urandom_range(0, 200)) - 100);
                    default: beats[i] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
                endcase
            end
            model(sgn, nb, r, o);
            exp_q.push_back({o, r});
            run_acc(which, sgn, nb, 2, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/s_cla_sacc_ctrl.md
Name: s_cla_sacc_ctrl

Overview:
Bit-serial shift-accumulate sequencer for the DCIM macro readout path. Consumes one signed partial sum per input-activation bit, MSB first, and folds each into a 24-bit accumulator: acc = 2*acc ± psum. A single shared 24-bit s_cla instance does the arithmetic. Sits between the column adder-tree output and the output buffer; one result per start.

Parameters:
IN_BITS, 8, number of activation bits (beats) per accumulation; legal range 2..16
PSUM_W, 16, partial-sum width (signed two's complement); must be < 24
ACC_W, 24, accumulator width; fixed to the s_cla width, not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin accumulation; sampled only in IDLE
in_signed  in  1  latched at start; 1 = activation MSB has weight -2^(IN_BITS-1)
psum  in  PSUM_W  signed partial sum for the current bit
psum_valid  in  1  psum beat valid
psum_ready  out  1  beat accepted when psum_valid & psum_ready
res  out  ACC_W  signed accumulated result
res_valid  out  1  result valid; held until accepted
res_ready  in  1  downstream accept
ovf  out  1  sticky overflow for the current result; valid with res_valid
busy  out  1  high in ACC and OUT

Behaviour:
- Reset (async, rst_n low): state=IDLE, acc=0, cnt=0, ovf=0, sgn=0, psum_ready=0, res_valid=0, busy=0, res=0. Reset mid-operation aborts with no partial output.
- States: IDLE -> ACC on start. ACC -> OUT on the accepted beat with cnt==IN_BITS-1. OUT -> IDLE on res_valid & res_ready.
- IDLE: psum_ready=0. start latches in_signed into sgn, clears acc, cnt, ovf. start is ignored in ACC and OUT.
- ACC: psum_ready=1 combinationally. No beat means acc and cnt hold, so bubbles are allowed.
- Per accepted beat: A = {acc[22:0],1'b0}. B = sign-extended psum to 24 bits. If cnt==0 and sgn: B = ~sext(psum), cin=1 (subtract). Otherwise cin=0. acc <= s_cla(A,B,cin). cnt++.
- Overflow (sets ovf, sticky): shift overflow when acc[23]!=acc[22] before the shift, or add overflow when A[23]==B[23] and sum[23]!=A[23].
- OUT: res_valid=1, res=acc, psum_ready=0. res and ovf are held stable while res_ready=0.
- Latency: first beat can be accepted the cycle after start. res_valid rises the cycle after the last beat is accepted. Minimum start-to-result latency is IN_BITS+1 cycles.
- Back-to-back: after the OUT handshake, state is IDLE for 1 cycle before the next start is accepted.

Optional Feature:
Macro SACC_SAT_EN.
- Defined: on the beat that first sets ovf, acc <= 24'h7FFFFF if the true result is positive, or 24'h800000 if negative. The sign source is acc[23] for shift overflow and A[23] for add overflow. acc is frozen for the remaining beats; beats are still consumed. ovf is still reported.
- Undefined: acc wraps modulo 2^24 and ovf is report-only.

Decomposition:
- Package sacc_pkg: state enum (IDLE, ACC, OUT), ACC_W=24, SAT_MAX=24'h7FFFFF, SAT_MIN=24'h800000, and the sign-extend function.
- Sub-module: exactly one instance of the existing s_cla (a, b, cin, sum). The FSM, counter, operand muxing and overflow logic stay in this module.

Test Plan:
- IN_BITS=8, in_signed=0, psum=1 on all 8 beats -> res=24'h0000FF, ovf=0.
- IN_BITS=8, in_signed=1, psum=1 on all beats -> -128+127: res=24'hFFFFFF, ovf=0. Then psum=3 on beat 0 only, 0 otherwise -> res=-384=24'hFFFE80.
- IN_BITS=8, in_signed=0, psum_valid toggled 1/0 every cycle, psum=-2 every beat -> res=-510=24'hFFFE02. Check bubbles do not advance cnt.
- IN_BITS=10, in_signed=0, psum=16'h7FFF on all beats -> ovf=1. Without SACC_SAT_EN, res = 33520641 mod 2^24 = 24'hFF7C01. With it, res=24'h7FFFFF.
- Backpressure: hold res_ready=0 for 5 cycles in OUT -> res, ovf, res_valid stable, psum_ready=0, and start pulses ignored. Then res_ready=1 -> IDLE next cycle.
- Assert rst_n low after beat 4 -> all outputs 0 immediately (async). A new start after release gives a correct, uncorrupted result.
